// File: rtl/dpkg_sort_buffer.sv
// rtl/dpkg_sort_buffer.sv - frame reorder buffer: high words first, then low words (DPKG_TYPE_TAG_EN adds out_type)
module dpkg_sort_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_type,
    input  logic                  in_fin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ADDR_WIDTH:0]   pkg_num,
    output logic [ADDR_WIDTH:0]   hi_num,
    output logic                  pkg_num_vld,
    output logic                  full
`ifdef DPKG_TYPE_TAG_EN
    ,
    output logic                  out_type
`endif
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int AW = ADDR_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {AW{1'b0}}};
`ifdef DPKG_TYPE_TAG_EN
    localparam int RW = DATA_WIDTH + 1;
`else
    localparam int RW = DATA_WIDTH;
`endif

    typedef enum logic {FILL, DRAIN} state_t;

    state_t         state;
    logic [RW-1:0]  ram [DEPTH];
    logic [CW-1:0]  hcnt, lcnt, count, rd_idx;
    logic [AW-1:0]  wr_addr, rd_addr, lo_idx;
    logic [RW-1:0]  wr_word;
    logic           accept, fill_close, load, last_load, out_hs;

    // High words live at DEPTH-1-hcnt, so no separate down-counting pointer is needed.
    assign count      = hcnt + lcnt;
    assign full       = (count == DEPTH_C);
    assign in_ready   = (state == FILL) && !full;
    assign accept     = in_valid && in_ready;
    assign fill_close = (state == FILL) && in_fin;
    assign wr_addr    = in_type ? ~hcnt[AW-1:0] : lcnt[AW-1:0];
`ifdef DPKG_TYPE_TAG_EN
    assign wr_word    = {in_type, in_data};
`else
    assign wr_word    = in_data;
`endif

    // Drain index walks 0..count-1: first the high region top-down, then the low region bottom-up.
    assign lo_idx     = rd_idx[AW-1:0] - hcnt[AW-1:0];
    assign rd_addr    = (rd_idx < hcnt) ? ~rd_idx[AW-1:0] : lo_idx;
    assign out_hs     = out_valid && out_ready;
    assign load       = (state == DRAIN) && (rd_idx != count) && (!out_valid || out_ready);
    assign last_load  = (rd_idx == count - CW'(1));

    always_ff @(posedge clk) begin
        if (accept)
            ram[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            hcnt        <= '0;
            lcnt        <= '0;
            rd_idx      <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            pkg_num     <= '0;
            hi_num      <= '0;
            pkg_num_vld <= 1'b0;
`ifdef DPKG_TYPE_TAG_EN
            out_type    <= 1'b0;
`endif
        end else begin
            pkg_num_vld <= fill_close;
            if (state == FILL) begin
                if (accept) begin
                    if (in_type)
                        hcnt <= hcnt + CW'(1);
                    else
                        lcnt <= lcnt + CW'(1);
                end
                if (in_fin) begin
                    pkg_num <= count + CW'(accept);
                    hi_num  <= hcnt + CW'(accept && in_type);
                    rd_idx  <= '0;
                    if (count != '0 || accept)
                        state <= DRAIN;
                end
            end else begin
                if (out_hs)
                    out_valid <= 1'b0;
                // The output register only advances when empty or being consumed, so stalled data holds.
                if (load) begin
                    out_valid <= 1'b1;
                    out_last  <= last_load;
                    rd_idx    <= rd_idx + CW'(1);
`ifdef DPKG_TYPE_TAG_EN
                    {out_type, out_data} <= ram[rd_addr];
`else
                    out_data  <= ram[rd_addr];
`endif
                end
                if (out_hs && out_last) begin
                    state    <= FILL;
                    hcnt     <= '0;
                    lcnt     <= '0;
                    rd_idx   <= '0;
                    out_last <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dpkg_sort_buffer.sv
// tb/tb_dpkg_sort_buffer.sv - randomized and directed bench for dpkg_sort_buffer against a queue model
module tb_dpkg_sort_buffer;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_type = 1'b0;
    logic          in_fin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW:0]   pkg_num;
    logic [AW:0]   hi_num;
    logic          pkg_num_vld;
    logic          full;
`ifdef DPKG_TYPE_TAG_EN
    logic          out_type;
`endif

    dpkg_sort_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_type(in_type), .in_fin(in_fin),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .pkg_num(pkg_num), .hi_num(hi_num),
        .pkg_num_vld(pkg_num_vld), .full(full)
`ifdef DPKG_TYPE_TAG_EN
        , .out_type(out_type)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;

    // Model: words of the open frame per class, and the expected output order once closed.
    logic [8:0] hq[$];
    logic [8:0] lq[$];
    logic [8:0] exp_q[$];
    bit  m_drain = 0;
    int  m_cnt = 0;
    int  m_since = 0;
    int  m_pkg = 0;
    int  m_hi = 0;
    bit  m_pv = 0;

    logic [8:0] cap_q[$];
    logic       tq[$];
    int close_cyc = 0;
    int first_vld_cyc = 0;
    int last_hs_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        bit e_ready, e_full, e_ov, was_drain, hs, pv_next;
        cyc++;
        if (!rst_n) begin
            hq.delete(); lq.delete(); exp_q.delete();
            m_drain = 0; m_cnt = 0; m_since = 0; m_pkg = 0; m_hi = 0; m_pv = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_pkg_num", pkg_num, 0);
            chk("rst_hi_num", hi_num, 0);
            chk("rst_pkg_num_vld", pkg_num_vld, 0);
            chk("rst_full", full, 0);
`ifdef DPKG_TYPE_TAG_EN
            chk("rst_out_type", out_type, 0);
`endif
        end else begin
            e_full  = (m_cnt == DEPTH);
            e_ready = !m_drain && !e_full;
            e_ov    = m_drain && m_since >= 2 && exp_q.size() > 0;
            chk("in_ready", in_ready, e_ready);
            chk("full", full, e_full);
            chk("out_valid", out_valid, e_ov);
            chk("pkg_num", pkg_num, m_pkg);
            chk("hi_num", hi_num, m_hi);
            chk("pkg_num_vld", pkg_num_vld, m_pv);
            if (e_ov) begin
                chk("out_data", out_data, exp_q[0][7:0]);
                chk("out_last", out_last, exp_q.size() == 1);
`ifdef DPKG_TYPE_TAG_EN
                chk("out_type", out_type, exp_q[0][8]);
`endif
            end
            if (out_valid && first_vld_cyc == 0) first_vld_cyc = cyc;
            was_drain = m_drain;
            hs = e_ov && out_ready;
            if (hs) begin
                cap_q.push_back({out_last, out_data});
                tq.push_back(exp_q[0][8]);
                last_hs_cyc = cyc;
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_drain = 0; m_cnt = 0; hq.delete(); lq.delete();
                end
            end
            pv_next = 0;
            if (!was_drain) begin
                if (in_valid && m_cnt < DEPTH) begin
                    if (in_type) hq.push_back({1'b1, in_data});
                    else         lq.push_back({1'b0, in_data});
                    m_cnt++;
                end
                if (in_fin) begin
                    pv_next = 1;
                    m_pkg = m_cnt;
                    m_hi = hq.size();
                    if (m_cnt > 0) begin
                        foreach (hq[i]) exp_q.push_back(hq[i]);
                        foreach (lq[i]) exp_q.push_back(lq[i]);
                        m_drain = 1;
                        m_since = 1;
                        close_cyc = cyc;
                    end
                end
            end else if (m_drain) begin
                m_since++;
            end
            m_pv = pv_next;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit t, input logic [7:0] d, input bit f);
        in_valid = v; in_type = t; in_data = d; in_fin = f;
        step();
        in_valid = 0; in_fin = 0;
    endtask

    task automatic wait_drain(input bit noisy);
        int i;
        for (i = 0; i < 400 && m_drain; i++) begin
            if (noisy) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            else step();
        end
        if (m_drain) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout cyc=%0d", cyc);
        end
    endtask

    task automatic clear_cap();
        cap_q.delete(); tq.delete(); first_vld_cyc = 0;
    endtask

    initial begin
        logic [8:0] exp_mix [4];
        repeat (3) step();
        chk("lit_reset_in_ready", in_ready, 1);
        chk("lit_reset_out_valid", out_valid, 0);
        rst_n = 1;
        step();

        // Mixed frame
        rdy_mode = 0;
        clear_cap();
        drive(1, 0, 8'h10, 0);
        drive(1, 1, 8'hA0, 0);
        drive(1, 0, 8'h11, 0);
        drive(1, 1, 8'hA1, 1);
        chk("lit_mix_pkg_vld", pkg_num_vld, 1);
        wait_drain(0);
        chk("lit_mix_pkg_num", pkg_num, 4);
        chk("lit_mix_hi_num", hi_num, 2);
        chk("lit_mix_size", cap_q.size(), 4);
        exp_mix = '{9'h0A0, 9'h0A1, 9'h010, 9'h111};
        for (int i = 0; i < 4 && i < cap_q.size(); i++)
            chk("lit_mix_word", cap_q[i], exp_mix[i]);
        chk("lit_mix_first_vld", first_vld_cyc - close_cyc, 2);
        chk("lit_mix_last_hs", last_hs_cyc - close_cyc, 5);
`ifdef DPKG_TYPE_TAG_EN
        for (int i = 0; i < 4 && i < tq.size(); i++)
            chk("lit_mix_type", tq[i], i < 2);
`endif
        chk("lit_mix_ready_back", in_ready, 1);

        // Single class frames
        clear_cap();
        drive(1, 1, 8'h31, 0);
        drive(1, 1, 8'h32, 0);
        drive(1, 1, 8'h33, 1);
        wait_drain(0);
        chk("lit_hi_last", cap_q.size() == 3 ? cap_q[2] : 9'h0, 9'h133);
        chk("lit_hi_first", cap_q.size() == 3 ? cap_q[0] : 9'h1FF, 9'h031);
        chk("lit_hi_gap", last_hs_cyc - close_cyc, 4);
        clear_cap();
        drive(1, 0, 8'h41, 0);
        drive(1, 0, 8'h42, 0);
        drive(1, 0, 8'h43, 1);
        wait_drain(0);
        chk("lit_lo_last", cap_q.size() == 3 ? cap_q[2] : 9'h0, 9'h143);
        chk("lit_lo_gap", last_hs_cyc - close_cyc, 4);

        // Full
        clear_cap();
        for (int i = 0; i < DEPTH; i++) drive(1, 1'(i % 3 == 0), 8'(8'h50 + i), 0);
        chk("lit_full", full, 1);
        chk("lit_full_in_ready", in_ready, 0);
        drive(1, 0, 8'hEE, 0);
        drive(0, 0, 8'h00, 1);
        wait_drain(0);
        chk("lit_full_pkg_num", pkg_num, 8);
        chk("lit_full_count", cap_q.size(), 8);
        foreach (cap_q[i]) if (cap_q[i][7:0] == 8'hEE) chk("lit_full_dropped", cap_q[i][7:0], 8'h00);

        // Backpressure
        clear_cap();
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) drive(1, 1'($urandom_range(0, 1)), 8'(8'h60 + i), i == 4);
        wait_drain(0);
        chk("lit_bp_count", cap_q.size(), 5);
        rdy_mode = 0;

        // Empty fin
        clear_cap();
        drive(0, 0, 8'h00, 1);
        chk("lit_empty_vld", pkg_num_vld, 1);
        chk("lit_empty_pkg", pkg_num, 0);
        repeat (4) step();
        chk("lit_empty_no_out", first_vld_cyc, 0);

        // Randomized frames with noisy input during drain
        rdy_mode = 1;
        for (int f = 0; f < 30; f++) begin
            int k;
            k = $urandom_range(0, 11);
            for (int i = 0; i < k; i++)
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1);
            wait_drain(1);
            step();
        end

        // Reset mid-drain
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) drive(1, 1'(i & 1), 8'(8'h70 + i), i == 5);
        repeat (3) step();
        rst_n = 0;
        step();
        chk("lit_mid_rst_out_valid", out_valid, 0);
        chk("lit_mid_rst_in_ready", in_ready, 1);
        step();
        rst_n = 1;
        rdy_mode = 0;
        clear_cap();
        repeat (5) step();
        chk("lit_post_rst_quiet", first_vld_cyc, 0);
        drive(1, 0, 8'h81, 0);
        drive(1, 1, 8'h82, 1);
        wait_drain(0);
        chk("lit_post_rst_count", cap_q.size(), 2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dpkg_sort_buffer.md
# dpkg_sort_buffer

- Frame-based packet reorder buffer with a single shared RAM of 2^ADDR_WIDTH words.
- Two classes of word are packed within a frame:
  - type=1 (high) words fill downward from the top address.
  - type=0 (low) words fill upward from address 0.
- On frame close, all high words are emitted first, then all low words, each class in arrival order, over a valid/ready stream.
- Sits between the packet ingress and downstream framer; successor of the two-type packager, adding parametric depth/width, output backpressure, full detection, per-class counts and multi-frame reuse.

## Interface
- DATA_WIDTH, 8, payload width.
- ADDR_WIDTH, 7, RAM address width; DEPTH = 2^ADDR_WIDTH.
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  buffer accepts input word.
- in_data  in  DATA_WIDTH  payload.
- in_type  in  1  1 = high class, 0 = low class.
- in_fin  in  1  frame close request; may coincide with in_valid.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  payload.
- out_last  out  1  final word of frame.
- pkg_num  out  ADDR_WIDTH+1  words in closed frame.
- hi_num  out  ADDR_WIDTH+1  high-class words in closed frame.
- pkg_num_vld  out  1  one-cycle strobe: counts valid.
- full  out  1  count == DEPTH.

## Operation
- States: FILL, DRAIN.
- FILL:
  - in_ready = ~full.
  - Word accepted when in_valid & in_ready.
  - Type 1 writes RAM[haddr] then haddr--; haddr resets to DEPTH-1.
  - Type 0 writes RAM[laddr] then laddr++; laddr resets to 0.
  - count = hcnt + lcnt, both ADDR_WIDTH+1 wide.
  - full = (count == DEPTH).
- Frame close:
  - in_fin sampled high in FILL closes the frame.
  - A word accepted in the same cycle belongs to the closing frame.
  - in_fin is ignored in DRAIN.
- Close with count > 0: go to DRAIN.
- Close with count == 0: stay in FILL; pkg_num_vld still pulses with pkg_num = hi_num = 0.
- DRAIN:
  - in_ready = 0.
  - Read order is DEPTH-1 down to haddr+1, then 0 up to laddr-1.
  - Addresses are not wrapped.
  - An empty class is skipped.
- out_last is 1 on the final word of the frame only.
- After the handshake of the last word:
  - Return to FILL.
  - haddr = DEPTH-1, laddr = 0, counts = 0.
  - RAM contents are not cleared.
- out_data/out_last hold stable while out_valid & ~out_ready.
- No word is dropped or duplicated under any out_ready pattern.
- pkg_num / hi_num:
  - Registered at close.
  - Held until the next close.
- Full:
  - in_valid while full is not accepted, and the data is not written.
  - in_fin is still honoured while full.
- Reset values:
  - State FILL.
  - in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
  - pkg_num = 0, hi_num = 0, pkg_num_vld = 0, full = 0.
- Reset mid-DRAIN aborts the frame; no further out_valid until a new frame closes.

## Timing
- Write: 1 cycle; the word is in RAM at the edge it is accepted.
- pkg_num_vld: asserted in the cycle after the close cycle T, i.e. T+1.
- First out_valid: at T+2 (RAM read is synchronous, 1-cycle latency, output registered).
- Throughput: 1 word/cycle with out_ready held high.
- Last word of an N-word frame under full throughput: handshakes at T+1+N.
- Back-to-back: in_ready returns to 1 the cycle after the last-word handshake.
- Backpressure: out_ready low for k cycles delays the stream by exactly k cycles.
  - A 1-entry skid or read-enable stall is permitted.
  - Ordering and the holding rule are mandatory.

## Configuration
- DPKG_TYPE_TAG_EN defined:
  - Adds output port out_type (1 bit), the class of the word on out_data.
  - The RAM stores DATA_WIDTH+1 bits per entry.
  - Reset value of out_type is 0.
- Not defined: no out_type port; RAM is DATA_WIDTH wide.
- All other behaviour is identical with and without the macro.

## Test plan
- Mixed frame:
  - Stimulus: write L0=0x10, H0=0xA0, L1=0x11, H1=0xA1, fin with the last word, out_ready=1.
  - Response:
    - pkg_num=4, hi_num=2.
    - Output order 0xA0, 0xA1, 0x10, 0x11.
    - out_last only on 0x11; first out_valid 2 cycles after fin.
- Single class:
  - Stimulus: 3 high-only words, then 3 low-only words in two separate frames.
  - Response: each frame drains in arrival order with out_last on the 3rd word; the empty class is skipped with no idle gap.
- Full:
  - Stimulus: ADDR_WIDTH=3, write 8 words.
  - Response:
    - full=1 and in_ready=0.
    - A 9th in_valid is not written.
    - fin gives pkg_num=8 and all 8 words out.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1 randomly during a 5-word drain.
  - Response: out_data is stable while stalled; exactly 5 handshakes, correct order.
- Empty fin and reset:
  - Stimulus: fin with no data; then assert rst_n low mid-drain.
  - Response:
    - For the empty fin: pkg_num_vld pulses with pkg_num=0 and there is no out_valid.
    - After reset: all outputs at reset values, state FILL.
- Tag (DPKG_TYPE_TAG_EN):
  - Stimulus: the mixed frame above.
  - Response: out_type sequence 1,1,0,0.
